// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin sharing of a single APB master port between
// NREQ requesters, with a PREADY timeout so a hung slave cannot hold the bus.
// Every output is driven straight from a flop; the combinational process
// computes next values and the sequential process registers them.
module apb_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr_rdn,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [DW-1:0]      rd_data,
    output logic               busy,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY
);

    localparam int   IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [IW-1:0]   w_grant_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [NREQ-1:0] w_done_nxt;
    logic            w_err_nxt;
    logic [DW-1:0]   w_rd_nxt;
    logic            w_pwrite_nxt;
    logic [AW-1:0]   w_paddr_nxt;
    logic [DW-1:0]   w_pwdata_nxt;
    logic [NREQ-1:0] w_mask;
    logic [IW:0]     w_pick;
    logic            w_win;
    logic [IW-1:0]   w_gidx;
    logic            w_launch;
    logic            w_complete;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    // First set bit of mask at or after ptr, wrapping modulo NREQ.
    // Result is {found, index}; scanning downwards makes the nearest one win.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (mask[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, arbitration and next-output computation.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = '0;
        w_err_nxt    = 1'b0;
        w_rd_nxt     = rd_data;
        w_pwrite_nxt = PWRITE;
        w_paddr_nxt  = PADDR;
        w_pwdata_nxt = PWDATA;
        w_launch     = 1'b0;
        w_complete   = 1'b0;

        // In IDLE a requester still seeing its done pulse is skipped; at the
        // end of a transfer the just-served requester is skipped instead.
        if (r_state == ST_IDLE) begin
            w_mask = req & ~done;
        end else begin
            w_mask = req & ~onehot(r_grant);
        end
        w_pick = rr_pick(w_mask, r_ptr);
        w_win  = w_pick[IW];
        w_gidx = w_pick[IW-1:0];

        case (r_state)
            ST_IDLE: begin
                if (w_win) begin
                    w_launch = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_cnt_nxt   = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // A ready on the timeout cycle is a normal completion.
                    w_complete = 1'b1;
                    if (!PWRITE) begin
                        w_rd_nxt = PRDATA;
                    end else begin
                        w_rd_nxt = rd_data;
                    end
                end else if (TO_EN && (r_cnt == CW'(TIMEOUT - 1))) begin
                    w_complete = 1'b1;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_complete) begin
            w_done_nxt = onehot(r_grant);
            if (w_win) begin
                w_launch = 1'b1;
            end else begin
                w_state_nxt  = ST_IDLE;
                w_paddr_nxt  = '0;
                w_pwdata_nxt = '0;
                w_pwrite_nxt = 1'b0;
            end
        end else begin
            w_done_nxt = '0;
        end

        if (w_launch) begin
            w_state_nxt  = ST_SETUP;
            w_grant_nxt  = w_gidx;
            w_paddr_nxt  = addr[int'(w_gidx)*AW +: AW];
            w_pwrite_nxt = wr_rdn[w_gidx];
            if (wr_rdn[w_gidx]) begin
                w_pwdata_nxt = wdata[int'(w_gidx)*DW +: DW];
            end else begin
                w_pwdata_nxt = '0;
            end
            if (w_gidx == IW'(NREQ - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_gidx + IW'(1);
            end
        end else begin
            w_grant_nxt = w_grant_nxt;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            done    <= '0;
            err     <= 1'b0;
            rd_data <= '0;
            busy    <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            done    <= w_done_nxt;
            err     <= w_err_nxt;
            rd_data <= w_rd_nxt;
            busy    <= (w_state_nxt != ST_IDLE);
            PSEL    <= (w_state_nxt != ST_IDLE);
            PENABLE <= (w_state_nxt == ST_ACCESS);
            PWRITE  <= w_pwrite_nxt;
            PADDR   <= w_paddr_nxt;
            PWDATA  <= w_pwdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter (NREQ=4, AW=DW=8, TIMEOUT=4).
// The slave echoes PADDR on PRDATA and answers ready in the first ACCESS
// cycle while slave_rdy is set.
module tb_apb_rr_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [3:0]  req;
    logic [3:0]  wr_rdn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  rd_data;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY;
    logic        slave_rdy;

    int checks = 0;
    int errors = 0;

    apb_rr_arbiter #(.NREQ(4), .AW(8), .DW(8), .TIMEOUT(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     (req),
        .wr_rdn  (wr_rdn),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .err     (err),
        .rd_data (rd_data),
        .busy    (busy),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA = PADDR;
    assign PREADY = slave_rdy & PSEL & PENABLE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
    endtask

    initial begin
        PRESETn   = 1'b0;
        req       = 4'b0000;
        wr_rdn    = 4'b0000;
        addr      = 32'h0;
        wdata     = 32'h0;
        slave_rdy = 1'b1;

        // Reset state
        do_reset();
        chk("rst_psel", {31'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_paddr", {24'd0, PADDR}, 32'd0);
        chk("rst_rd", {24'd0, rd_data}, 32'd0);

        // Single write from requester 0
        addr[7:0]  = 8'h10;
        wdata[7:0] = 8'hA5;
        wr_rdn[0]  = 1'b1;
        req[0]     = 1'b1;
        step();
        chk("wr_setup_psel", {31'd0, PSEL}, 32'd1);
        chk("wr_setup_pen", {31'd0, PENABLE}, 32'd0);
        chk("wr_setup_paddr", {24'd0, PADDR}, 32'h10);
        chk("wr_setup_pwrite", {31'd0, PWRITE}, 32'd1);
        chk("wr_setup_pwdata", {24'd0, PWDATA}, 32'hA5);
        chk("wr_setup_busy", {31'd0, busy}, 32'd1);
        step();
        chk("wr_access_pen", {31'd0, PENABLE}, 32'd1);
        chk("wr_access_paddr", {24'd0, PADDR}, 32'h10);
        chk("wr_access_pwdata", {24'd0, PWDATA}, 32'hA5);
        chk("wr_access_done", {28'd0, done}, 32'd0);
        step();
        chk("wr_done", {28'd0, done}, 32'h1);
        chk("wr_err", {31'd0, err}, 32'd0);
        chk("wr_idle_psel", {31'd0, PSEL}, 32'd0);
        chk("wr_idle_paddr", {24'd0, PADDR}, 32'd0);
        chk("wr_rd_unchanged", {24'd0, rd_data}, 32'd0);
        // req[0] still high while its done shows: must not be re-granted
        step();
        chk("wr_no_regrant", {31'd0, PSEL}, 32'd0);
        chk("wr_done_once", {28'd0, done}, 32'd0);
        req[0] = 1'b0;

        // Single read from requester 2; its wdata must not reach PWDATA
        addr[23:16]  = 8'h33;
        wdata[23:16] = 8'h77;
        wr_rdn[2]    = 1'b0;
        req[2]       = 1'b1;
        step();
        chk("rd_setup_paddr", {24'd0, PADDR}, 32'h33);
        chk("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("rd_setup_pwdata", {24'd0, PWDATA}, 32'd0);
        // changing the command after grant has no effect
        addr[23:16] = 8'h99;
        step();
        chk("rd_access_paddr", {24'd0, PADDR}, 32'h33);
        step();
        chk("rd_done", {28'd0, done}, 32'h4);
        chk("rd_data", {24'd0, rd_data}, 32'h33);
        req[2] = 1'b0;
        step();
        chk("rd_done_once", {28'd0, done}, 32'd0);
        chk("rd_data_hold", {24'd0, rd_data}, 32'h33);

        // Round robin from a fresh pointer: grants 0,1,2,3 back to back
        do_reset();
        addr   = 32'h43424140;
        wdata  = 32'hEEEEEEEE;
        wr_rdn = 4'b0000;
        req    = 4'b1111;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_psel", i), {31'd0, PSEL}, 32'd1);
            chk($sformatf("rr%0d_pen", i), {31'd0, PENABLE}, 32'd0);
            chk($sformatf("rr%0d_paddr", i), {24'd0, PADDR}, 32'h40 + i);
            chk($sformatf("rr%0d_done", i), {28'd0, done},
                (i == 0) ? 32'd0 : (32'd1 << (i - 1)));
            if (i > 0) begin
                chk($sformatf("rr%0d_rd", i), {24'd0, rd_data}, 32'h40 + i - 1);
                req[i-1] = 1'b0;
            end
            step();
            chk($sformatf("rr%0d_access", i), {31'd0, PENABLE}, 32'd1);
            step();
        end
        chk("rr_last_done", {28'd0, done}, 32'h8);
        chk("rr_last_idle", {31'd0, PSEL}, 32'd0);
        chk("rr_last_rd", {24'd0, rd_data}, 32'h43);
        req[3] = 1'b0;
        step();

        // Fairness: requesters 1 and 3 held continuously alternate 1,3,1,3
        req = 4'b1010;
        step();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("fair%0d_paddr", j), {24'd0, PADDR},
                (j % 2 == 0) ? 32'h41 : 32'h43);
            step();
            if (j == 3) begin
                req = 4'b0000;
            end
            step();
        end
        chk("fair_last_done", {28'd0, done}, 32'h8);
        chk("fair_last_idle", {31'd0, PSEL}, 32'd0);
        step();

        // Timeout: requester 1 read with a hung slave
        slave_rdy = 1'b0;
        req[1]    = 1'b1;
        step();
        chk("to_setup_paddr", {24'd0, PADDR}, 32'h41);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("to_wait%0d_pen", k), {31'd0, PENABLE}, 32'd1);
            chk($sformatf("to_wait%0d_done", k), {28'd0, done}, 32'd0);
        end
        step();
        chk("to_done", {28'd0, done}, 32'h2);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rd_keep", {24'd0, rd_data}, 32'h43);
        chk("to_idle", {31'd0, PSEL}, 32'd0);
        req[1] = 1'b0;
        step();
        chk("to_err_pulse", {31'd0, err}, 32'd0);

        // Next request after the timeout proceeds normally
        slave_rdy    = 1'b1;
        addr[23:16]  = 8'h52;
        wdata[23:16] = 8'h99;
        wr_rdn[2]    = 1'b1;
        req[2]       = 1'b1;
        step();
        chk("post_to_paddr", {24'd0, PADDR}, 32'h52);
        chk("post_to_pwdata", {24'd0, PWDATA}, 32'h99);
        step();
        step();
        chk("post_to_done", {28'd0, done}, 32'h4);
        chk("post_to_err", {31'd0, err}, 32'd0);
        req[2] = 1'b0;
        step();

        // Reset in the middle of ACCESS
        slave_rdy = 1'b0;
        req[3]    = 1'b1;
        step();
        step();
        chk("mid_access", {31'd0, PENABLE}, 32'd1);
        PRESETn = 1'b0;
        step();
        chk("mrst_psel", {31'd0, PSEL}, 32'd0);
        chk("mrst_pen", {31'd0, PENABLE}, 32'd0);
        chk("mrst_done", {28'd0, done}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rd", {24'd0, rd_data}, 32'd0);
        PRESETn   = 1'b1;
        slave_rdy = 1'b1;
        req       = 4'b1001;
        step();
        chk("mrst_first_grant", {24'd0, PADDR}, 32'h40);
        req = 4'b0000;
        step();
        step();
        chk("mrst_first_done", {28'd0, done}, 32'h1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
